// File: rtl/scaler_vline_stepper_if.sv
// Handshake and data bundle between the scaler line engine / config generator
// (master side) and the vertical line stepper (slave side).
interface scaler_vline_stepper_if #(
    parameter int PHASE_W = 6
);
    logic               frame_start_i;
    logic               line_req_i;
    logic [9:0]         vpos_1st_rdline_i;
    logic [9:0]         vlines_in_needed_i;
    logic [10:0]        vlines_out_i;
    logic [17:0]        v_interp_factor_i;
    logic               ready_o;
    logic               busy_o;
    logic               line_valid_o;
    logic [9:0]         rdline_a_o;
    logic [9:0]         rdline_b_o;
    logic [PHASE_W-1:0] vphase_o;
    logic [10:0]        out_line_cnt_o;
    logic               frame_done_o;

    modport master (
        output frame_start_i, line_req_i, vpos_1st_rdline_i, vlines_in_needed_i,
               vlines_out_i, v_interp_factor_i,
        input  ready_o, busy_o, line_valid_o, rdline_a_o, rdline_b_o, vphase_o,
               out_line_cnt_o, frame_done_o
    );

    modport slave (
        input  frame_start_i, line_req_i, vpos_1st_rdline_i, vlines_in_needed_i,
               vlines_out_i, v_interp_factor_i,
        output ready_o, busy_o, line_valid_o, rdline_a_o, rdline_b_o, vphase_o,
               out_line_cnt_o, frame_done_o
    );
endinterface

// File: rtl/scaler_vline_stepper.sv
// Per-frame vertical source-line stepper. For every output line it hands the
// line engine the two buffered source lines to blend and the weight of the
// lower one, walking a 12.17 fixed-point accumulator down the source image.
// Optional feature: define SCALER_VSTEP_CENTER_EN for centre-aligned sampling
// (accumulator starts half a step minus half a line in); otherwise top-aligned.
module scaler_vline_stepper #(
    parameter int PHASE_W = 6
) (
    input  logic                          VCLK,
    input  logic                          nRST,
    scaler_vline_stepper_if.slave         bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP1,
        ST_SETUP2,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         vpos_q, vpos_d;
    logic [9:0]         vin_q, vin_d;
    logic [10:0]        vout_q, vout_d;
    logic [17:0]        fac_q, fac_d;
    logic [27:0]        step_q, step_d;
    logic [28:0]        acc_q, acc_d;
    logic [10:0]        cnt_q, cnt_d;
    logic               lineValid_q, lineValid_d;
    logic               frameDone_q, frameDone_d;
    logic [9:0]         rdA_q, rdA_d;
    logic [9:0]         rdB_q, rdB_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [10:0]        outCnt_q, outCnt_d;

    logic [11:0]        accInt;
    logic [9:0]         lmax;
    logic [9:0]         aSel;
    logic [9:0]         bSel;
    logic [10:0]        aPlus1;
    logic [PHASE_W-1:0] phaseSel;
    logic [28:0]        initVal;

    // Source line pair and weight for the current accumulator, clamped to the last line
    always_comb begin
        accInt = acc_q[28:17];
        lmax   = vin_q - 10'd1;
        if (accInt > {2'b00, lmax}) begin
            aSel     = lmax;
            phaseSel = '0;
        end else begin
            aSel     = accInt[9:0];
            phaseSel = acc_q[16 -: PHASE_W];
        end
        aPlus1 = {1'b0, aSel} + 11'd1;
        bSel   = (aPlus1 > {1'b0, lmax}) ? lmax : aPlus1[9:0];
    end

    // Accumulator start value: top-aligned, or centred on the first output line
    always_comb begin
        initVal = '0;
`ifdef SCALER_VSTEP_CENTER_EN
        if (step_q > 28'd131072) begin
            initVal = {2'b00, step_q[27:1]} - 29'd65536;
        end
`endif
    end

    // Next-state and registered-output logic; frame_start overrides everything
    always_comb begin
        state_d     = state_q;
        vpos_d      = vpos_q;
        vin_d       = vin_q;
        vout_d      = vout_q;
        fac_d       = fac_q;
        step_d      = step_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        lineValid_d = 1'b0;
        frameDone_d = 1'b0;
        rdA_d       = rdA_q;
        rdB_d       = rdB_q;
        phase_d     = phase_q;
        outCnt_d    = outCnt_q;

        if (bus.frame_start_i) begin
            vpos_d  = bus.vpos_1st_rdline_i;
            vin_d   = bus.vlines_in_needed_i;
            vout_d  = bus.vlines_out_i;
            fac_d   = bus.v_interp_factor_i;
            state_d = ST_SETUP1;
        end else begin
            case (state_q)
                ST_SETUP1: begin
                    step_d  = {18'd0, vin_q} * {10'd0, fac_q};
                    state_d = ST_SETUP2;
                end
                ST_SETUP2: begin
                    acc_d = initVal;
                    cnt_d = '0;
                    if (vout_q == 11'd0 || vin_q == 10'd0) begin
                        frameDone_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.line_req_i) begin
                        lineValid_d = 1'b1;
                        rdA_d       = vpos_q + aSel;
                        rdB_d       = vpos_q + bSel;
                        phase_d     = phaseSel;
                        outCnt_d    = cnt_q;
                        acc_d       = acc_q + {1'b0, step_q};
                        cnt_d       = cnt_q + 11'd1;
                        if (cnt_q == vout_q - 11'd1) begin
                            frameDone_d = 1'b1;
                            state_d     = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, shadow config, accumulator and output registers
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_IDLE;
            vpos_q      <= '0;
            vin_q       <= '0;
            vout_q      <= '0;
            fac_q       <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            lineValid_q <= 1'b0;
            frameDone_q <= 1'b0;
            rdA_q       <= '0;
            rdB_q       <= '0;
            phase_q     <= '0;
            outCnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            vpos_q      <= vpos_d;
            vin_q       <= vin_d;
            vout_q      <= vout_d;
            fac_q       <= fac_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            lineValid_q <= lineValid_d;
            frameDone_q <= frameDone_d;
            rdA_q       <= rdA_d;
            rdB_q       <= rdB_d;
            phase_q     <= phase_d;
            outCnt_q    <= outCnt_d;
        end
    end

    assign bus.ready_o        = (state_q == ST_RUN);
    assign bus.busy_o         = (state_q == ST_SETUP1) || (state_q == ST_SETUP2);
    assign bus.line_valid_o   = lineValid_q;
    assign bus.frame_done_o   = frameDone_q;
    assign bus.rdline_a_o     = rdA_q;
    assign bus.rdline_b_o     = rdB_q;
    assign bus.vphase_o       = phase_q;
    assign bus.out_line_cnt_o = outCnt_q;

endmodule

// File: tb/tb_scaler_vline_stepper.sv
// Randomized scoreboard bench for scaler_vline_stepper. The stimulus side keeps
// a frame-level model (config, setup countdown, line index) and pushes the
// expected response, computed in closed form as init + k*step, into a queue;
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_scaler_vline_stepper;

    localparam int PHASE_W = 6;

    logic VCLK = 1'b0;
    logic nRST;

    // Free-running video clock
    always #5 VCLK = ~VCLK;

    scaler_vline_stepper_if #(.PHASE_W(PHASE_W)) bus ();

    scaler_vline_stepper #(.PHASE_W(PHASE_W)) dut (
        .VCLK (VCLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        bit isLine;
        bit done;
        int rda;
        int rdb;
        int ph;
        int cnt;
        int cyc;
    } exp_t;

    exp_t expQ[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cycleCnt   = 0;

    int cVpos, cVin, cVout, cFac;
    int mVpos, mVin, mVout, mFac;
    int setupLeft = 0;
    bit runMode   = 1'b0;
    int lineIdx   = 0;

    // Cycle counter used to pin the one-cycle response latency
    always @(posedge VCLK) cycleCnt <= cycleCnt + 1;

    // Expected response for output line k of the current frame
    function automatic exp_t expectLine(input int k);
        exp_t   e;
        longint step, init, acc, intPart, lmax, a, b, ph;
        step = longint'(mVin) * longint'(mFac);
        init = 0;
`ifdef SCALER_VSTEP_CENTER_EN
        if (step > 131072) init = step / 2 - 65536;
`endif
        acc     = (init + longint'(k) * step) % (longint'(1) << 29);
        intPart = acc >> 17;
        lmax    = mVin - 1;
        if (intPart > lmax) begin
            a  = lmax;
            ph = 0;
        end else begin
            a  = intPart;
            ph = (acc >> (17 - PHASE_W)) % (longint'(1) << PHASE_W);
        end
        b = (a + 1 > lmax) ? lmax : a + 1;
        e.isLine = 1'b1;
        e.done   = (k == mVout - 1);
        e.rda    = int'((mVpos + a) % 1024);
        e.rdb    = int'((mVpos + b) % 1024);
        e.ph     = int'(ph);
        e.cnt    = k;
        e.cyc    = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One clock cycle of stimulus: checks status flags, drives inputs, advances the model
    task automatic applyStimulus(input bit fs, input bit req);
        exp_t e;
        @(posedge VCLK);
        #1;
        checkOutput("ready_o", int'(bus.ready_o), int'(runMode));
        checkOutput("busy_o", int'(bus.busy_o), int'(setupLeft > 0));
        bus.frame_start_i      = fs;
        bus.line_req_i         = req;
        bus.vpos_1st_rdline_i  = 10'(cVpos);
        bus.vlines_in_needed_i = 10'(cVin);
        bus.vlines_out_i       = 11'(cVout);
        bus.v_interp_factor_i  = 18'(cFac);
        if (fs) begin
            mVpos = cVpos; mVin = cVin; mVout = cVout; mFac = cFac;
            setupLeft = 2;
            runMode   = 1'b0;
        end else if (setupLeft == 2) begin
            setupLeft = 1;
        end else if (setupLeft == 1) begin
            setupLeft = 0;
            if (mVout == 0 || mVin == 0) begin
                e = '{isLine: 1'b0, done: 1'b1, rda: 0, rdb: 0, ph: 0, cnt: 0, cyc: cycleCnt + 1};
                expQ.push_back(e);
            end else begin
                runMode = 1'b1;
                lineIdx = 0;
            end
        end else if (runMode && req) begin
            e     = expectLine(lineIdx);
            e.cyc = cycleCnt + 1;
            expQ.push_back(e);
            if (lineIdx == mVout - 1) runMode = 1'b0;
            lineIdx++;
        end
    endtask

    // Start a frame (with a coincident request) and run it; abortAfter >= 0 returns early
    task automatic runFrame(input int vin, input int vpos, input int vout, input int fac,
                            input int reqPct, input int abortAfter);
        bit finished;
        cVin = vin; cVpos = vpos; cVout = vout; cFac = fac;
        applyStimulus(1'b1, 1'b1);
        finished = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (abortAfter >= 0 && runMode && lineIdx == abortAfter) return;
            if (setupLeft == 0 && !runMode) begin
                finished = 1'b1;
                break;
            end
            applyStimulus(1'b0, $urandom_range(0, 99) < reqPct);
        end
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL frame_timeout: frame vin=%0d vout=%0d still active after budget", vin, vout);
        end
    endtask

    // Scoreboard monitor: every DUT response is matched against the head of the queue
    always @(negedge VCLK) begin
        exp_t e;
        if (nRST && (bus.line_valid_o || bus.frame_done_o)) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_response: got lv=%0d done=%0d cnt=%0d a=%0d, required none",
                         bus.line_valid_o, bus.frame_done_o, bus.out_line_cnt_o, bus.rdline_a_o);
            end else begin
                e = expQ.pop_front();
                if (int'(bus.line_valid_o) != int'(e.isLine) || int'(bus.frame_done_o) != int'(e.done) ||
                    cycleCnt != e.cyc ||
                    (e.isLine && (int'(bus.rdline_a_o) != e.rda || int'(bus.rdline_b_o) != e.rdb ||
                                  int'(bus.vphase_o) != e.ph || int'(bus.out_line_cnt_o) != e.cnt))) begin
                    miscompares++;
                    $display("[TB] FAIL response: got lv=%0d done=%0d cyc=%0d a=%0d b=%0d ph=%0d cnt=%0d, required lv=%0d done=%0d cyc=%0d a=%0d b=%0d ph=%0d cnt=%0d",
                             bus.line_valid_o, bus.frame_done_o, cycleCnt, bus.rdline_a_o, bus.rdline_b_o,
                             bus.vphase_o, bus.out_line_cnt_o, e.isLine, e.done, e.cyc, e.rda, e.rdb, e.ph, e.cnt);
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, int'(bus.ready_o), 0);
        checkOutput({tag, "_busy"}, int'(bus.busy_o), 0);
        checkOutput({tag, "_line_valid"}, int'(bus.line_valid_o), 0);
        checkOutput({tag, "_frame_done"}, int'(bus.frame_done_o), 0);
        checkOutput({tag, "_rdline_a"}, int'(bus.rdline_a_o), 0);
        checkOutput({tag, "_rdline_b"}, int'(bus.rdline_b_o), 0);
        checkOutput({tag, "_vphase"}, int'(bus.vphase_o), 0);
        checkOutput({tag, "_out_cnt"}, int'(bus.out_line_cnt_o), 0);
    endtask

    initial begin
        int rVout;
        nRST = 1'b0;
        bus.frame_start_i = 1'b0; bus.line_req_i = 1'b0;
        bus.vpos_1st_rdline_i = '0; bus.vlines_in_needed_i = '0;
        bus.vlines_out_i = '0; bus.v_interp_factor_i = '0;
        cVin = 0; cVpos = 0; cVout = 0; cFac = 0;
        repeat (3) @(posedge VCLK);
        #2;
        checkAllZero("reset");
        @(negedge VCLK);
        nRST = 1'b1;

        $display("[TB] T1 step 0.5, then abort at line 100 with new vpos");
        runFrame(256, 16, 512, 256, 80, -1);
        runFrame(256, 16, 512, 256, 100, 100);
        runFrame(256, 0, 512, 256, 100, -1);

        $display("[TB] T2 step 2.0 and T3 step ~0.5");
        runFrame(256, 16, 128, 1024, 100, -1);
        runFrame(240, 0, 480, 273, 60, -1);

        $display("[TB] T5 empty frames");
        runFrame(256, 16, 0, 0, 100, -1);
        runFrame(0, 5, 10, 13107, 100, -1);

        $display("[TB] async reset mid-frame");
        runFrame(100, 900, 300, 436, 70, 50);
        applyStimulus(1'b0, 1'b0);
        @(negedge VCLK);
        #1;
        nRST = 1'b0;
        #1;
        checkAllZero("midreset");
        runMode = 1'b0;
        setupLeft = 0;
        #1;
        nRST = 1'b1;

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            rVout = $urandom_range(1, 300);
            runFrame($urandom_range(1, 1023), $urandom_range(0, 1023), rVout, 131072 / rVout,
                     $urandom_range(30, 100), -1);
        end

        repeat (5) applyStimulus(1'b0, 1'b0);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
